// File: rtl/pipe_reg_hs_pkg.sv
// Shared helpers for the handshaked pipe register: occupancy counter sizing.
package pipe_reg_hs_pkg;

  // Bits needed to count 0..pipes valid stages inclusive.
  function automatic int occ_width(input int pipes);
    return $clog2(pipes + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Valid/ready bundle between an FPU stage producer, the pipe register and its consumer.
interface pipe_reg_hs_if #(
  parameter int NUM_OF_BITS  = 27,
  parameter int NUM_OF_PIPES = 2
);
  import pipe_reg_hs_pkg::*;

  localparam int OCC_W = occ_width(NUM_OF_PIPES);

  logic                   flush;
  logic                   in_valid;
  logic [NUM_OF_BITS-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [NUM_OF_BITS-1:0] out_data;
  logic                   out_ready;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_hs.sv
// One valid/data register of the pipe; loads from its source when advanced, clears on flush.
module pipe_stage_hs #(
  parameter int NUM_OF_BITS = 27
) (
  input  logic                   clk_pll,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   adv,
  input  logic                   src_valid,
  input  logic [NUM_OF_BITS-1:0] src_data,
  output logic                   vld_q,
  output logic [NUM_OF_BITS-1:0] data_q
);

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      // NOTE: the payload register is reset as well so out_data reads 0 after rst.
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (clear) begin
      vld_q <= 1'b0;
    end else if (adv) begin
      vld_q <= src_valid;
      // NOTE: payload captures only valid sources so bubbles never toggle the datapath.
      if (src_valid) data_q <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// Parametrised valid/ready pipe register with flush, occupancy and selectable stall mode.
module pipe_reg_hs
  import pipe_reg_hs_pkg::*;
#(
  parameter int NUM_OF_BITS     = 27,
  parameter int NUM_OF_PIPES    = 2,
  parameter int BUBBLE_COLLAPSE = 1
) (
  input logic         clk_pll,
  input logic         rst,
  pipe_reg_hs_if.slave bus
);

  localparam int LAST  = NUM_OF_PIPES - 1;
  localparam int OCC_W = occ_width(NUM_OF_PIPES);

  logic [LAST:0]          vld_q;
  logic [LAST:0]          adv;
  logic [NUM_OF_BITS-1:0] data_q [NUM_OF_PIPES];
  logic [OCC_W-1:0]       occ_q;
  logic                   in_xfer;
  logic                   out_xfer;

  for (genvar i = 0; i < NUM_OF_PIPES; i++) begin : g_stage
    logic                   src_valid;
    logic [NUM_OF_BITS-1:0] src_data;

    // The collapse ready chain unrolls to: some stage at or after i is empty, or the output drains.
    if (BUBBLE_COLLAPSE != 0) begin : g_collapse
      assign adv[i] = !(&vld_q[LAST:i]) || bus.out_ready;
    end else begin : g_global
      assign adv[i] = !vld_q[LAST] || bus.out_ready;
    end

    if (i == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_data  = bus.in_data;
    end else begin : g_body
      assign src_valid = vld_q[i-1];
      assign src_data  = data_q[i-1];
    end

    pipe_stage_hs #(.NUM_OF_BITS(NUM_OF_BITS)) u_stage (
      .clk_pll   (clk_pll),
      .rst       (rst),
      .clear     (bus.flush),
      .adv       (adv[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .vld_q     (vld_q[i]),
      .data_q    (data_q[i])
    );
  end

  assign bus.in_ready  = adv[0] && !bus.flush && !rst;
  assign bus.out_valid = vld_q[LAST];
  assign bus.out_data  = data_q[LAST];
  assign bus.occupancy = occ_q;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // Internal stage moves never change the valid count, so only the two transfers adjust it.
  always_ff @(posedge clk_pll) begin
    if (rst || bus.flush) occ_q <= '0;
    else                  occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Drives three pipe_reg_hs configurations with shared stimulus; each has a queue-based reference model.
module tb_pipe_reg_hs;

  localparam int W = 27;

  logic         clk_pll = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_pll = ~clk_pll;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One in-flight item: payload and the stage index it currently occupies.
  typedef struct {
    logic [W-1:0] data;
    int           s;
  } item_t;

  // g=0: 2 stages collapse, g=1: 4 stages collapse, g=2: 4 stages global stall.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P  = (g == 0) ? 2 : 4;
    localparam int BC = (g == 2) ? 0 : 1;

    pipe_reg_hs_if #(.NUM_OF_BITS(W), .NUM_OF_PIPES(P)) bus ();

    assign bus.flush     = flush;
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;

    pipe_reg_hs #(.NUM_OF_BITS(W), .NUM_OF_PIPES(P), .BUBBLE_COLLAPSE(BC)) u_dut (
      .clk_pll (clk_pll),
      .rst     (rst),
      .bus     (bus)
    );

    item_t        q[$];
    item_t        nq[$];
    item_t        it;
    logic [W-1:0] last_data = '0;
    logic         ov;
    logic         rdy;
    logic         in_rdy;
    int           limit;

    // Monitor: compare the DUT against the model, then advance the model over the coming edge.
    always @(negedge clk_pll) begin
      ov     = (q.size() > 0) && (q[0].s == P - 1);
      rdy    = (BC != 0) ? ((q.size() < P) || out_ready) : (!ov || out_ready);
      in_rdy = rdy && !flush && !rst;

      check($sformatf("dut%0d out_valid", g), 64'(bus.out_valid), 64'(ov));
      check($sformatf("dut%0d out_data", g), 64'(bus.out_data), 64'(last_data));
      check($sformatf("dut%0d in_ready", g), 64'(bus.in_ready), 64'(in_rdy));
      check($sformatf("dut%0d occupancy", g), 64'(bus.occupancy), 64'(q.size()));
      if (ov && out_ready)
        check($sformatf("dut%0d order", g), 64'(bus.out_data), 64'(q[0].data));

      if (rst) begin
        q.delete();
        last_data = '0;
      end else if (flush) begin
        q.delete();
      end else if (BC == 0) begin
        if (rdy) begin
          if (ov) void'(q.pop_front());
          foreach (q[k]) begin
            q[k].s++;
            if (q[k].s == P - 1) last_data = q[k].data;
          end
          if (in_valid && in_rdy) begin
            it.data = in_data;
            it.s    = 0;
            q.push_back(it);
            if (P == 1) last_data = in_data;
          end
        end
      end else begin
        // Items pack towards the output: each moves one stage unless the item ahead blocks it.
        limit = P;
        nq.delete();
        for (int k = 0; k < q.size(); k++) begin
          if (k == 0 && ov && out_ready) continue;
          it   = q[k];
          it.s = (it.s + 1 < limit) ? it.s + 1 : limit - 1;
          if (it.s == P - 1 && q[k].s != P - 1) last_data = it.data;
          limit = it.s;
          nq.push_back(it);
        end
        if (in_valid && in_rdy) begin
          it.data = in_data;
          it.s    = 0;
          nq.push_back(it);
          if (P == 1) last_data = in_data;
        end
        q = nq;
      end
    end
  end

  task automatic step();
    @(posedge clk_pll);
    #1;
  endtask

  initial begin
    logic [W-1:0] stall_data [11];
    logic         stall_vld  [11];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk_pll);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk_pll);
    check("p2 rst out_valid", 64'(g_dut[0].bus.out_valid), 64'd0);
    check("p2 rst out_data", 64'(g_dut[0].bus.out_data), 64'd0);
    check("p2 rst occupancy", 64'(g_dut[0].bus.occupancy), 64'd0);
    check("p2 rst in_ready", 64'(g_dut[0].bus.in_ready), 64'd1);
    check("c4 rst occupancy", 64'(g_dut[1].bus.occupancy), 64'd0);
    check("c4 rst in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
    check("g4 rst occupancy", 64'(g_dut[2].bus.occupancy), 64'd0);
    check("g4 rst in_ready", 64'(g_dut[2].bus.in_ready), 64'd1);
    step();

    // Latency: 0x1..0x5 back to back into the 2-stage pipe.
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5);
      in_data  = W'(c + 1);
      @(negedge clk_pll);
      check("p2 lat in_ready", 64'(g_dut[0].bus.in_ready), 64'd1);
      if (c >= 2 && c <= 6) begin
        check("p2 lat out_valid", 64'(g_dut[0].bus.out_valid), 64'd1);
        check("p2 lat out_data", 64'(g_dut[0].bus.out_data), 64'(c - 1));
      end
      if (c >= 2 && c <= 5)
        check("p2 lat occupancy", 64'(g_dut[0].bus.occupancy), 64'd2);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Stall: 0xA, 3-cycle gap, 0xB, then fill with 0xC..0xE while out_ready=0.
    stall_vld  = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    stall_data = '{W'('hA), 0, 0, 0, W'('hB), 0, 0, W'('hC), W'('hD), W'('hE), W'('hE)};
    out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      in_valid = stall_vld[c];
      in_data  = stall_data[c];
      @(negedge clk_pll);
      if (c == 4) begin
        check("c4 stall in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
        check("g4 stall in_ready", 64'(g_dut[2].bus.in_ready), 64'd0);
      end
      if (c == 7) begin
        check("c4 collapse occupancy", 64'(g_dut[1].bus.occupancy), 64'd2);
        check("c4 collapse in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
        check("g4 bubble occupancy", 64'(g_dut[2].bus.occupancy), 64'd1);
        check("g4 bubble in_ready", 64'(g_dut[2].bus.in_ready), 64'd0);
      end
      if (c >= 9) begin
        check("c4 full occupancy", 64'(g_dut[1].bus.occupancy), 64'd4);
        check("c4 full in_ready", 64'(g_dut[1].bus.in_ready), 64'd0);
        check("c4 full out_data", 64'(g_dut[1].bus.out_data), 64'hA);
      end
      step();
    end

    // Full throughput at full occupancy.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h10 + k);
      @(negedge clk_pll);
      check("c4 thru occupancy", 64'(g_dut[1].bus.occupancy), 64'd4);
      check("c4 thru in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
      check("c4 thru out_valid", 64'(g_dut[1].bus.out_valid), 64'd1);
      step();
    end

    // Flush with occupancy 3 while 0x7 is offered.
    in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h7); flush = 1'b1;
    @(negedge clk_pll);
    check("c4 flush occupancy", 64'(g_dut[1].bus.occupancy), 64'd3);
    check("c4 flush in_ready", 64'(g_dut[1].bus.in_ready), 64'd0);
    check("g4 flush in_ready", 64'(g_dut[2].bus.in_ready), 64'd0);
    check("c4 flush out_valid", 64'(g_dut[1].bus.out_valid), 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_pll);
      check("c4 post-flush out_valid", 64'(g_dut[1].bus.out_valid), 64'd0);
      check("c4 post-flush occupancy", 64'(g_dut[1].bus.occupancy), 64'd0);
      step();
    end

    // Random traffic with occasional flush and one mid-stream reset.
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = (k < 400) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0) && (k != 701);
      rst       = (k == 700);
      @(negedge clk_pll);
      if (k == 701) begin
        check("c4 mid-rst out_valid", 64'(g_dut[1].bus.out_valid), 64'd0);
        check("c4 mid-rst out_data", 64'(g_dut[1].bus.out_data), 64'd0);
        check("c4 mid-rst occupancy", 64'(g_dut[1].bus.occupancy), 64'd0);
        check("c4 mid-rst in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
        check("g4 mid-rst out_data", 64'(g_dut[2].bus.out_data), 64'd0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
